// File: rtl/dhm_pmu_pkg.sv
//------------------------------------------------------------------------------
// Module      : dhm_pmu_pkg
// Description : Shared types and default timing constants for the dhm_pmu
//               power-management sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package dhm_pmu_pkg;

    // Width of the shared down-counter used for every timed phase
    localparam int unsigned CNT_W = 8;

    // Default phase lengths, in clk cycles
    localparam int unsigned DEF_SAVE_CYC    = 2;
    localparam int unsigned DEF_RESTORE_CYC = 2;
    localparam int unsigned DEF_RST_CYC     = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;

    // Sequencer states: reset hold, running, sleep handshake, retention save,
    // powered off, reset release, retention restore, wake handshake
    typedef enum logic [2:0] {
        ST_PRST = 3'd0,
        ST_ON   = 3'd1,
        ST_SREQ = 3'd2,
        ST_SAVE = 3'd3,
        ST_OFF  = 3'd4,
        ST_PREL = 3'd5,
        ST_REST = 3'd6,
        ST_WAKE = 3'd7
    } pmu_state_e;

    // Load value for the down-counter from an integer cycle count
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dhm_pmu.sv
//------------------------------------------------------------------------------
// Module      : dhm_pmu
// Description : Power-down / power-up sequencer for a retention power domain.
//               Handshakes sleep with the core, strobes retention save and
//               restore, and controls the domain reset. All outputs are
//               registered; every _n output has its own complement flop.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dhm_pmu
    import dhm_pmu_pkg::*;
#(
    parameter int unsigned SAVE_CYC    = DEF_SAVE_CYC,
    parameter int unsigned RESTORE_CYC = DEF_RESTORE_CYC,
    parameter int unsigned RST_CYC     = DEF_RST_CYC,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pd_req,
    input  logic i_pu_req,
    input  logic sleep_ack,
    output logic sleep,
    output logic sleep_n,
    output logic rreg_save,
    output logic rreg_save_n,
    output logic rreg_restore,
    output logic rreg_restore_n,
    output logic pd_reset_n,
    output logic o_off,
    output logic o_busy,
    output logic o_err
);

    localparam logic [CNT_W-1:0] C_SAVE_CNT    = cnt_load(SAVE_CYC);
    localparam logic [CNT_W-1:0] C_RESTORE_CNT = cnt_load(RESTORE_CYC);
    localparam logic [CNT_W-1:0] C_RST_CNT     = cnt_load(RST_CYC);
    localparam logic [CNT_W-1:0] C_ACK_CNT     = cnt_load(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

    pmu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sleep_q, sleep_d;
    logic             save_q, save_d;
    logic             restore_q, restore_d;
    logic             pdrst_n_q, pdrst_n_d;
    logic             off_q, off_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             sleep_n_q, save_n_q, restore_n_q;

    // A phase ends when the counter is on its last cycle (<= 1 guards a zero load)
    logic w_last;
    assign w_last = (cnt_q <= C_ONE);

    // Next-state and next-output decode; outputs are computed here so they
    // can be registered together with the state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sleep_d   = sleep_q;
        save_d    = save_q;
        restore_d = restore_q;
        pdrst_n_d = pdrst_n_q;
        off_d     = off_q;
        busy_d    = busy_q;
        err_d     = 1'b0;

        case (state_q)
            ST_PRST: begin
                if (w_last) begin
                    state_d   = ST_ON;
                    pdrst_n_d = 1'b1;
                    sleep_d   = 1'b0;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_ON: begin
                // Only the power-down request is meaningful while running
                if (i_pd_req) begin
                    state_d = ST_SREQ;
                    sleep_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = C_ACK_CNT;
                end
            end
            ST_SREQ: begin
                // An acknowledge on the final cycle still wins over the timeout
                if (sleep_ack) begin
                    state_d = ST_SAVE;
                    save_d  = 1'b1;
                    cnt_d   = C_SAVE_CNT;
                end else if (w_last) begin
                    state_d = ST_ON;
                    sleep_d = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_SAVE: begin
                if (w_last) begin
                    state_d   = ST_OFF;
                    save_d    = 1'b0;
                    pdrst_n_d = 1'b0;
                    off_d     = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_OFF: begin
                // Only the power-up request is meaningful while off
                if (i_pu_req) begin
                    state_d   = ST_PREL;
                    pdrst_n_d = 1'b1;
                    off_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_PREL: begin
                // Domain reset has been released for one cycle before restore
                state_d   = ST_REST;
                restore_d = 1'b1;
                cnt_d     = C_RESTORE_CNT;
            end
            ST_REST: begin
                if (w_last) begin
                    state_d   = ST_WAKE;
                    restore_d = 1'b0;
                    sleep_d   = 1'b0;
                    cnt_d     = C_ACK_CNT;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_WAKE: begin
                if (!sleep_ack) begin
                    state_d = ST_ON;
                    busy_d  = 1'b0;
                end else if (w_last) begin
                    state_d = ST_ON;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: begin
                state_d   = ST_PRST;
                cnt_d     = C_RST_CNT;
                sleep_d   = 1'b0;
                save_d    = 1'b0;
                restore_d = 1'b0;
                pdrst_n_d = 1'b0;
                off_d     = 1'b0;
                busy_d    = 1'b1;
            end
        endcase
    end

    // State, counter and output registers; complements are separate flops
    // loaded from the inverted next value so each pair is exact every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PRST;
            cnt_q       <= C_RST_CNT;
            sleep_q     <= 1'b0;
            sleep_n_q   <= 1'b1;
            save_q      <= 1'b0;
            save_n_q    <= 1'b1;
            restore_q   <= 1'b0;
            restore_n_q <= 1'b1;
            pdrst_n_q   <= 1'b0;
            off_q       <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sleep_q     <= sleep_d;
            sleep_n_q   <= ~sleep_d;
            save_q      <= save_d;
            save_n_q    <= ~save_d;
            restore_q   <= restore_d;
            restore_n_q <= ~restore_d;
            pdrst_n_q   <= pdrst_n_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign sleep          = sleep_q;
    assign sleep_n        = sleep_n_q;
    assign rreg_save      = save_q;
    assign rreg_save_n    = save_n_q;
    assign rreg_restore   = restore_q;
    assign rreg_restore_n = restore_n_q;
    assign pd_reset_n     = pdrst_n_q;
    assign o_off          = off_q;
    assign o_busy         = busy_q;
    assign o_err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dhm_pmu.sv
//------------------------------------------------------------------------------
// Module      : tb_dhm_pmu
// Description : Self-checking bench for dhm_pmu. Phase timings are measured
//               on the outputs and compared with values computed from the
//               sequencing rules and the configured cycle counts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dhm_pmu;

    localparam int SAVE_CYC    = 2;
    localparam int RESTORE_CYC = 2;
    localparam int RST_CYC     = 4;
    localparam int ACK_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset_n, i_pd_req, i_pu_req, sleep_ack;
    logic sleep, sleep_n, rreg_save, rreg_save_n, rreg_restore, rreg_restore_n;
    logic pd_reset_n, o_off, o_busy, o_err;

    int  checks = 0;
    int  errors = 0;
    bit  core_follow = 1'b0;

    always #5 clk = ~clk;

    dhm_pmu #(
        .SAVE_CYC    (SAVE_CYC),
        .RESTORE_CYC (RESTORE_CYC),
        .RST_CYC     (RST_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pd_req       (i_pd_req),
        .i_pu_req       (i_pu_req),
        .sleep_ack      (sleep_ack),
        .sleep          (sleep),
        .sleep_n        (sleep_n),
        .rreg_save      (rreg_save),
        .rreg_save_n    (rreg_save_n),
        .rreg_restore   (rreg_restore),
        .rreg_restore_n (rreg_restore_n),
        .pd_reset_n     (pd_reset_n),
        .o_off          (o_off),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    // Simple core: acknowledge mirrors sleep shortly after each edge
    always @(posedge clk) begin
        #2;
        if (core_follow) sleep_ack = sleep;
    end

    // Cycle invariants: complements, strobe exclusivity, strobes only out of reset
    always @(negedge clk) begin
        checks++;
        if (sleep_n !== ~sleep || rreg_save_n !== ~rreg_save || rreg_restore_n !== ~rreg_restore) begin
            errors++;
            $display("FAIL complement @%0t: sleep=%b/%b save=%b/%b restore=%b/%b", $time,
                     sleep, sleep_n, rreg_save, rreg_save_n, rreg_restore, rreg_restore_n);
        end
        checks++;
        if ((rreg_save === 1'b1 && rreg_restore === 1'b1) ||
            ((rreg_save === 1'b1 || rreg_restore === 1'b1) && pd_reset_n !== 1'b1)) begin
            errors++;
            $display("FAIL strobe_exclusive @%0t: save=%b restore=%b pd_reset_n=%b required no overlap",
                     $time, rreg_save, rreg_restore, pd_reset_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0; i_pd_req = 1'b0; i_pu_req = 1'b0; sleep_ack = 1'b0;
        repeat (3) tick();
        checks++;
        if ({sleep, sleep_n, rreg_save, rreg_save_n, rreg_restore, rreg_restore_n,
             pd_reset_n, o_off, o_busy, o_err} !== 10'b01_01_01_0010) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", {sleep, sleep_n, rreg_save, rreg_save_n,
                     rreg_restore, rreg_restore_n, pd_reset_n, o_off, o_busy, o_err}, 10'b0101010010);
        end
        reset_n = 1'b1;
        n = 0;
        while (pd_reset_n !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != RST_CYC) begin
            errors++;
            $display("FAIL reset_hold: pd_reset_n low %0d cycles, required %0d", n, RST_CYC);
        end
        checks++;
        if (o_busy !== 1'b0 || sleep !== 1'b0 || o_off !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_on: busy=%b sleep=%b off=%b required 0 0 0", o_busy, sleep, o_off);
        end
    endtask

    // From ON: request power-down; the core acknowledges d cycles after sleep rises
    task automatic test_power_down(input int d);
        int save_first, save_cnt, off_at, err_at, err_cnt, exp_off;
        bit exp_err;
        save_first = -1; save_cnt = 0; off_at = -1; err_at = -1; err_cnt = 0;
        exp_err = (d >= ACK_TIMEOUT);
        exp_off = d + 1 + SAVE_CYC;
        i_pd_req = 1'b1;
        tick();
        i_pd_req = 1'b0;
        checks++;
        if (sleep !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pd_sleep_rise: sleep=%b busy=%b required 1 1", sleep, o_busy);
        end
        if (d == 0) sleep_ack = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rreg_save === 1'b1) begin
                if (save_first < 0) save_first = i;
                save_cnt++;
            end
            if (o_err === 1'b1) begin
                if (err_at < 0) err_at = i;
                err_cnt++;
            end
            if (i == d) sleep_ack = 1'b1;
            if (o_off === 1'b1) begin
                off_at = i;
                break;
            end
            if (err_at >= 0 && i > err_at + 2) break;
        end
        if (!exp_err) begin
            checks++;
            if (save_first != d + 1 || save_cnt != SAVE_CYC) begin
                errors++;
                $display("FAIL pd_save_pulse: start %0d width %0d, required start %0d width %0d",
                         save_first, save_cnt, d + 1, SAVE_CYC);
            end
            checks++;
            if (off_at != exp_off || err_cnt != 0) begin
                errors++;
                $display("FAIL pd_off_timing: off at %0d err %0d, required off at %0d err 0",
                         off_at, err_cnt, exp_off);
            end
            checks++;
            if (pd_reset_n !== 1'b0 || sleep !== 1'b1 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL pd_off_outputs: pd_reset_n=%b sleep=%b busy=%b required 0 1 0",
                         pd_reset_n, sleep, o_busy);
            end
        end else begin
            sleep_ack = 1'b0;
            checks++;
            if (err_at != ACK_TIMEOUT || err_cnt != 1 || save_cnt != 0) begin
                errors++;
                $display("FAIL pd_timeout: err at %0d count %0d saves %0d, required at %0d count 1 saves 0",
                         err_at, err_cnt, save_cnt, ACK_TIMEOUT);
            end
            checks++;
            if (sleep !== 1'b0 || o_busy !== 1'b0 || o_off !== 1'b0 || pd_reset_n !== 1'b1) begin
                errors++;
                $display("FAIL pd_timeout_on: sleep=%b busy=%b off=%b pd_reset_n=%b required 0 0 0 1",
                         sleep, o_busy, o_off, pd_reset_n);
            end
        end
    endtask

    // From OFF: request power-up; the core drops its ack dd cycles after sleep falls
    task automatic test_power_up(input int dd);
        int rest_first, rest_cnt, fall_at, on_at, err_at, err_cnt, pd_low, exp_fall, exp_on;
        bit exp_err;
        rest_first = -1; rest_cnt = 0; fall_at = -1; on_at = -1; err_at = -1; err_cnt = 0; pd_low = 0;
        exp_err  = (dd >= ACK_TIMEOUT);
        exp_fall = RESTORE_CYC + 1;
        exp_on   = exp_fall + (exp_err ? ACK_TIMEOUT : dd + 1);
        i_pu_req = 1'b1;
        tick();
        i_pu_req = 1'b0;
        checks++;
        if (pd_reset_n !== 1'b1 || o_off !== 1'b0 || o_busy !== 1'b1 || rreg_restore !== 1'b0) begin
            errors++;
            $display("FAIL pu_release: pd_reset_n=%b off=%b busy=%b restore=%b required 1 0 1 0",
                     pd_reset_n, o_off, o_busy, rreg_restore);
        end
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (rreg_restore === 1'b1) begin
                if (rest_first < 0) rest_first = i;
                rest_cnt++;
            end
            if (pd_reset_n !== 1'b1) pd_low++;
            if (o_err === 1'b1) begin
                if (err_at < 0) err_at = i;
                err_cnt++;
            end
            if (sleep === 1'b0 && fall_at < 0) fall_at = i;
            if (fall_at >= 0 && i == fall_at + dd) sleep_ack = 1'b0;
            if (o_busy === 1'b0 && on_at < 0) on_at = i;
            if (on_at >= 0 && i > on_at + 1) break;
        end
        sleep_ack = 1'b0;
        checks++;
        if (rest_first != 1 || rest_cnt != RESTORE_CYC || pd_low != 0) begin
            errors++;
            $display("FAIL pu_restore_pulse: start %0d width %0d pd_low %0d, required start 1 width %0d pd_low 0",
                     rest_first, rest_cnt, pd_low, RESTORE_CYC);
        end
        checks++;
        if (fall_at != exp_fall || on_at != exp_on) begin
            errors++;
            $display("FAIL pu_wake_timing: sleep fall %0d on %0d, required fall %0d on %0d",
                     fall_at, on_at, exp_fall, exp_on);
        end
        checks++;
        if (err_cnt != (exp_err ? 1 : 0) || (exp_err && err_at != exp_on)) begin
            errors++;
            $display("FAIL pu_wake_err: err count %0d at %0d, required count %0d at %0d",
                     err_cnt, err_at, exp_err ? 1 : 0, exp_on);
        end
    endtask

    task automatic test_timeout();
        int quiet;
        test_power_down(ACK_TIMEOUT + int'($urandom_range(0, 3)));
        quiet = 0;
        repeat (4) begin
            tick();
            if (o_busy === 1'b0 && sleep === 1'b0 && o_err === 1'b0) quiet++;
        end
        checks++;
        if (quiet != 4) begin
            errors++;
            $display("FAIL timeout_stays_on: idle cycles %0d, required 4", quiet);
        end
    endtask

    // Requests outside their own state are ignored and not remembered
    task automatic test_ignored_requests();
        int n, held;
        i_pu_req = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_busy !== 1'b0 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL on_ignores_pu: busy=%b sleep=%b required 0 0", o_busy, sleep);
        end
        i_pd_req = 1'b1;
        tick();
        i_pd_req = 1'b0;
        checks++;
        if (sleep !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL both_req_in_on: sleep=%b busy=%b required 1 1", sleep, o_busy);
        end
        tick();
        i_pu_req  = 1'b0;
        sleep_ack = 1'b1;
        n = 0;
        while (o_off !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        held = 0;
        i_pd_req = 1'b1;
        repeat (4) begin
            tick();
            if (o_off === 1'b1 && pd_reset_n === 1'b0 && sleep === 1'b1) held++;
        end
        i_pd_req = 1'b0;
        repeat (2) begin
            tick();
            if (o_off === 1'b1 && pd_reset_n === 1'b0) held++;
        end
        checks++;
        if (held != 6) begin
            errors++;
            $display("FAIL off_ignores_pd: off cycles %0d, required 6", held);
        end
    endtask

    task automatic test_reset_mid_save();
        int n;
        i_pd_req = 1'b1;
        tick();
        i_pd_req  = 1'b0;
        sleep_ack = 1'b1;
        n = 0;
        while (rreg_save !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL abort_save_start: save rose after %0d cycles, required 1", n);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({sleep, sleep_n, rreg_save, rreg_save_n, rreg_restore, rreg_restore_n,
             pd_reset_n, o_off, o_busy, o_err} !== 10'b01_01_01_0010) begin
            errors++;
            $display("FAIL abort_async: got %b required %b", {sleep, sleep_n, rreg_save, rreg_save_n,
                     rreg_restore, rreg_restore_n, pd_reset_n, o_off, o_busy, o_err}, 10'b0101010010);
        end
        tick();
        sleep_ack = 1'b0;
        reset_n   = 1'b1;
        n = 0;
        while (pd_reset_n !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != RST_CYC || o_busy !== 1'b0 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL abort_recover: hold %0d busy=%b sleep=%b, required hold %0d busy 0 sleep 0",
                     n, o_busy, sleep, RST_CYC);
        end
    endtask

    // Both requests held: the sequencer should cycle down/up with a fixed period
    task automatic test_back_to_back();
        int rises[$];
        int errs, period;
        logic prev;
        errs   = 0;
        period = 5 + SAVE_CYC + RESTORE_CYC;
        core_follow = 1'b1;
        i_pd_req = 1'b1;
        i_pu_req = 1'b1;
        prev = sleep;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (sleep === 1'b1 && prev === 1'b0) rises.push_back(i);
            if (o_err === 1'b1) errs++;
            prev = sleep;
        end
        i_pd_req = 1'b0;
        i_pu_req = 1'b0;
        checks++;
        if (rises.size() != (79 / period) + 1 || rises[0] != 0 || errs != 0) begin
            errors++;
            $display("FAIL b2b_cycles: %0d cycles first at %0d errs %0d, required %0d first at 0 errs 0",
                     rises.size(), rises.size() > 0 ? rises[0] : -1, errs, (79 / period) + 1);
        end
        for (int k = 1; k < rises.size(); k++) begin
            checks++;
            if (rises[k] - rises[k-1] != period) begin
                errors++;
                $display("FAIL b2b_period: spacing %0d, required %0d", rises[k] - rises[k-1], period);
            end
        end
    endtask

    initial begin
        test_reset();
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            test_power_down(int'($urandom_range(0, ACK_TIMEOUT - 1)));
            test_power_up(int'($urandom_range(0, ACK_TIMEOUT - 1)));
        end
        test_power_down(3);
        test_power_up(0);
        test_timeout();
        test_power_down(1);
        test_power_up(ACK_TIMEOUT + int'($urandom_range(0, 2)));
        test_ignored_requests();
        test_power_up(2);
        test_reset_mid_save();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/dhm_pmu.md
DHM_PMU -- requirements
Module: dhm_pmu

Interface
REQ-001 Parameter SAVE_CYC, default 2, width of the rreg_save pulse in cycles (1..255) SHALL be supported.
REQ-002 Parameter RESTORE_CYC, default 2, width of the rreg_restore pulse in cycles (1..255) SHALL be supported.
REQ-003 Parameter RST_CYC, default 4, number of cycles pd_reset_n is held low after reset_n deassertion (1..255) SHALL be supported.
REQ-004 Parameter ACK_TIMEOUT, default 255, max cycles to wait for a sleep_ack edge (1..255) SHALL be supported.
REQ-005 clk  input  1  single clock for all state.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_pd_req  input  1  level; power-down request.
REQ-008 i_pu_req  input  1  level; power-up request.
REQ-009 sleep_ack  input  1  core acknowledge; synchronous to clk.
REQ-010 sleep, sleep_n  output  1 each  core sleep request and its complement.
REQ-011 rreg_save, rreg_save_n  output  1 each  retention save strobe and complement.
REQ-012 rreg_restore, rreg_restore_n  output  1 each  retention restore strobe and complement.
REQ-013 pd_reset_n  output  1  power-domain reset, active-low.
REQ-014 o_off  output  1  high while in OFF; o_busy  output  1  high in any state other than ON/OFF.
REQ-015 o_err  output  1  one-cycle pulse on handshake timeout.

Function
REQ-016 All outputs SHALL be registered; each _n output SHALL be the exact bitwise complement of its partner every cycle.
REQ-017 FSM states SHALL be PRST, ON, SREQ, SAVE, OFF, PREL, REST, WAKE, with an 8-bit down-counter cnt.
REQ-018 PRST: pd_reset_n=0, sleep=0; after RST_CYC cycles go ON.
REQ-019 ON: pd_reset_n=1, sleep=0; i_pd_req=1 -> SREQ next cycle, sleep=1 from that cycle, cnt=ACK_TIMEOUT.
REQ-020 SREQ: sleep_ack=1 -> SAVE; rreg_save=1 for exactly SAVE_CYC cycles beginning the next cycle.
REQ-021 SREQ: cnt reaches 0 without sleep_ack -> ON, sleep=0, o_err=1 for one cycle.
REQ-022 SAVE complete -> OFF: rreg_save=0, pd_reset_n=0, sleep held 1.
REQ-023 OFF: i_pu_req=1 -> PREL: pd_reset_n=1 next cycle, held one cycle, then REST.
REQ-024 REST: rreg_restore=1 for exactly RESTORE_CYC cycles, then WAKE with sleep=0, cnt=ACK_TIMEOUT.
REQ-025 WAKE: sleep_ack=0 -> ON; cnt reaches 0 with sleep_ack still 1 -> ON with o_err=1 for one cycle.
REQ-026 rreg_save and rreg_restore SHALL never be high in the same cycle; neither SHALL be high while pd_reset_n=0.
REQ-027 Requests SHALL be sampled only in ON (i_pd_req) and OFF (i_pu_req); in all other states both are ignored and not queued.
REQ-028 Both requests high simultaneously: only the one relevant to the current state (ON/OFF) SHALL act.
REQ-029 i_pd_req held high continuously SHALL re-trigger power-down on the cycle after returning to ON.

Reset
REQ-030 reset_n low SHALL asynchronously force state PRST, cnt=RST_CYC, sleep=0, rreg_save=0, rreg_restore=0, pd_reset_n=0, o_off=0, o_busy=1, o_err=0 (complements accordingly).
REQ-031 Reset asserted mid-sequence (any state) SHALL abort it with no further strobes; after release the block SHALL follow PRST -> ON.

Structure
REQ-032 Package dhm_pmu_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-033 The block SHALL be a single module with no sub-modules; it instantiates next to dhm_core, driving that core's sleep/retention/pd_reset_n ports and receiving its sleep_ack.

Verification
REQ-034 Reset release, defaults -> pd_reset_n low 4 cycles, then ON, o_busy=0.
REQ-035 i_pd_req pulse, sleep_ack rises 3 cycles after sleep -> rreg_save high exactly 2 cycles, then pd_reset_n=0, o_off=1, sleep=1.
REQ-036 From OFF, i_pu_req pulse -> pd_reset_n=1, rreg_restore high exactly 2 cycles, sleep=0; sleep_ack drop -> ON.
REQ-037 ACK_TIMEOUT=8, sleep_ack tied 0, i_pd_req -> o_err single pulse 8 cycles after sleep rises, back in ON, no rreg_save.
REQ-038 reset_n asserted during SAVE cycle 1 -> rreg_save falls immediately, state PRST, complements consistent.
REQ-039 i_pd_req and i_pu_req both held high -> continuous full down/up cycling; assertions REQ-016/026 never fail.
